// File: rtl/route_switch.sv
// rtl/route_switch.sv - joins routing decisions with flits, queues them and steers each to the core or a router port
//
// Ports:
//   clk, rst_n                     clock; asynchronous active-low reset
//   ctrl_valid/ctrl_ready          routing decision handshake
//   ctrl_core, ctrl_dir            1 = deliver to core; else router direction 0..3
//   pkt_valid/pkt_ready/pkt_data   flit handshake; flit[ADDR_W-1:0] is the hop address
//   core_valid/core_ready/core_data  local core output (flit unmodified)
//   rt_valid[4]/rt_ready[4]/rt_data  router outputs; rt_valid is one-hot per direction
//   level                          FIFO occupancy
module route_switch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ctrl_valid,
    output logic                       ctrl_ready,
    input  logic                       ctrl_core,
    input  logic [1:0]                 ctrl_dir,
    input  logic                       pkt_valid,
    output logic                       pkt_ready,
    input  logic [DATA_W-1:0]          pkt_data,
    output logic                       core_valid,
    input  logic                       core_ready,
    output logic [DATA_W-1:0]          core_data,
    output logic [3:0]                 rt_valid,
    input  logic [3:0]                 rt_ready,
    output logic [DATA_W-1:0]          rt_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_W + 3;

    // Entry layout: {core, dir[1:0], flit}
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   addr_mask;
    logic [DATA_W-1:0]   wr_flit;
    logic [EW-1:0]       head;
    logic                head_core;
    logic [1:0]          head_dir;
    logic [DATA_W-1:0]   head_flit;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Both channels are consumed together; readiness depends only on the
    // registered occupancy, so a pop never opens room for a same-cycle push.
    assign push       = ctrl_valid & pkt_valid & ~full;
    assign ctrl_ready = push;
    assign pkt_ready  = push;

    // The consumed hop bit is cleared on the way in, so the queued entry
    // already carries the address the next router will see.
    always_comb begin
        addr_mask           = '0;
        addr_mask[ctrl_dir] = 1'b1;
        wr_flit             = pkt_data;
        if (!ctrl_core) begin
            wr_flit = pkt_data & ~{{(DATA_W-ADDR_W){1'b0}}, addr_mask};
        end
    end

    assign head      = mem[rd_ptr];
    assign head_core = head[EW-1];
    assign head_dir  = head[EW-2:EW-3];
    assign head_flit = head[DATA_W-1:0];

    // Outputs come straight from the stored head; with an empty FIFO they are
    // forced to zero, which also makes an asynchronous reset clear them at once.
    always_comb begin
        core_valid = 1'b0;
        rt_valid   = '0;
        core_data  = '0;
        rt_data    = '0;
        if (!empty) begin
            core_data = head_flit;
            rt_data   = head_flit;
            if (head_core) begin
                core_valid = 1'b1;
            end else begin
                rt_valid[head_dir] = 1'b1;
            end
        end
    end

    assign pop = (core_valid & core_ready) | (|(rt_valid & rt_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ctrl_core, ctrl_dir, wr_flit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_route_switch.sv
// tb/tb_route_switch.sv - directed self-checking bench for route_switch
module tb_route_switch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        ctrl_core;
    logic [1:0]  ctrl_dir;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [15:0] pkt_data;
    logic        core_valid;
    logic        core_ready;
    logic [15:0] core_data;
    logic [3:0]  rt_valid;
    logic [3:0]  rt_ready;
    logic [15:0] rt_data;
    logic [1:0]  level;

    int n_checks = 0;
    int n_pass   = 0;

    route_switch #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .ctrl_core  (ctrl_core),
        .ctrl_dir   (ctrl_dir),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_data  (core_data),
        .rt_valid   (rt_valid),
        .rt_ready   (rt_ready),
        .rt_data    (rt_data),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic core, input logic [1:0] dir, input logic [15:0] data);
        ctrl_valid = 1'b1;
        pkt_valid  = 1'b1;
        ctrl_core  = core;
        ctrl_dir   = dir;
        pkt_data   = data;
    endtask

    task automatic clear_pair();
        ctrl_valid = 1'b0;
        pkt_valid  = 1'b0;
    endtask

    logic [15:0] exp_flit;

    initial begin
        rst_n      = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_core  = 1'b0;
        ctrl_dir   = 2'd0;
        pkt_valid  = 1'b0;
        pkt_data   = 16'h0;
        core_ready = 1'b0;
        rt_ready   = 4'b0;

        // Reset state
        tick();
        tick();
        check("rst_level", level, 0);
        check("rst_core_valid", core_valid, 0);
        check("rst_rt_valid", rt_valid, 0);
        check("rst_core_data", core_data, 0);
        check("rst_rt_data", rt_data, 0);
        rst_n = 1'b1;
        tick();

        // Router entry dir 2, address bit 2 cleared
        set_pair(1'b0, 2'd2, 16'h00A4);
        #1;
        check("t1_ctrl_ready", ctrl_ready, 1);
        check("t1_pkt_ready", pkt_ready, 1);
        check("t1_no_comb_path", rt_valid, 0);
        tick();
        clear_pair();
        check("t1_rt_valid", rt_valid, 4'b0100);
        check("t1_rt_data", rt_data, 16'h00A0);
        check("t1_level", level, 1);
        check("t1_core_valid", core_valid, 0);
        rt_ready = 4'b0100;
        tick();
        rt_ready = 4'b0;
        check("t1_level_after_pop", level, 0);
        check("t1_rt_valid_after_pop", rt_valid, 0);

        // Core entry, flit unmodified
        core_ready = 1'b1;
        set_pair(1'b1, 2'd3, 16'h1230);
        tick();
        clear_pair();
        check("t2_core_valid", core_valid, 1);
        check("t2_core_data", core_data, 16'h1230);
        check("t2_rt_valid", rt_valid, 0);
        tick();
        core_ready = 1'b0;
        check("t2_core_valid_drop", core_valid, 0);

        // Lone pkt_valid waits
        pkt_valid = 1'b1;
        pkt_data  = 16'h0055;
        ctrl_core = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_pkt_ready_lone", pkt_ready, 0);
            check("t3_ctrl_ready_lone", ctrl_ready, 0);
            tick();
        end
        check("t3_level_no_push", level, 0);
        ctrl_valid = 1'b1;
        #1;
        check("t3_pkt_ready_join", pkt_ready, 1);
        tick();
        clear_pair();
        check("t3_level_push", level, 1);
        check("t3_core_data", core_data, 16'h0055);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        check("t3_level_drain", level, 0);

        // Fill, head-of-line blocking, full with same-cycle pop
        set_pair(1'b0, 2'd1, 16'h00FF);
        tick();
        set_pair(1'b0, 2'd3, 16'h00FF);
        tick();
        set_pair(1'b0, 2'd0, 16'h0F0F);
        #1;
        check("t4_level_full", level, 2);
        check("t4_ready_full", ctrl_ready, 0);
        check("t4_head_valid", rt_valid, 4'b0010);
        check("t4_head_data", rt_data, 16'h00FD);
        rt_ready = 4'b1000;
        tick();
        check("t4_hol_level", level, 2);
        check("t4_hol_valid", rt_valid, 4'b0010);
        rt_ready = 4'b0010;
        #1;
        check("t4_ready_on_pop_cycle", pkt_ready, 0);
        tick();
        rt_ready = 4'b0;
        check("t4_level_after_pop", level, 1);
        check("t4_next_head_valid", rt_valid, 4'b1000);
        check("t4_next_head_data", rt_data, 16'h00F7);
        check("t4_third_ready", ctrl_ready, 1);
        tick();
        clear_pair();
        check("t4_third_pushed", level, 2);
        rt_ready = 4'b1000;
        tick();
        check("t4_third_head_valid", rt_valid, 4'b0001);
        check("t4_third_head_data", rt_data, 16'h0F0E);
        rt_ready = 4'b0001;
        tick();
        rt_ready = 4'b0;
        check("t4_empty", level, 0);

        // Continuous stream alternating core / dir0
        core_ready = 1'b1;
        rt_ready   = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                set_pair(1'b1, 2'd0, 16'hC000 | 16'(k));
            end else begin
                set_pair(1'b0, 2'd0, 16'hD001 | 16'(k << 4));
            end
            tick();
            check("t5_level", level, 1);
            if (k % 2 == 0) begin
                exp_flit = 16'hC000 | 16'(k);
                check("t5_core_valid", core_valid, 1);
                check("t5_core_data", core_data, exp_flit);
            end else begin
                exp_flit = (16'hD001 | 16'(k << 4)) & 16'hFFFE;
                check("t5_rt_valid", rt_valid, 4'b0001);
                check("t5_rt_data", rt_data, exp_flit);
            end
        end
        clear_pair();
        tick();
        check("t5_drained", level, 0);
        core_ready = 1'b0;
        rt_ready   = 4'b0;

        // Asynchronous reset mid-stream
        set_pair(1'b1, 2'd0, 16'hBEEF);
        tick();
        set_pair(1'b0, 2'd1, 16'h00F2);
        tick();
        clear_pair();
        check("t6_level_before", level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_level", level, 0);
        check("t6_async_core_valid", core_valid, 0);
        check("t6_async_core_data", core_data, 0);
        check("t6_async_rt_valid", rt_valid, 0);
        tick();
        rst_n = 1'b1;
        core_ready = 1'b1;
        rt_ready   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_stale_core", core_valid, 0);
            check("t6_no_stale_rt", rt_valid, 0);
        end
        check("t6_level_after", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
